// File: rtl/drum_step_sequencer.sv
// Drum-machine playback sequencer: sample-rate divider, 16-step pattern player,
// per-voice go/busy tracking and time-slotting of the shared sample ROM.
module drum_step_sequencer #(
    parameter int NUM_VOICES       = 3,
    parameter int STEPS            = 16,
    parameter int CLK_PER_SAMPLE   = 1042,
    parameter int SAMPLES_PER_STEP = 6000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic        i_pat_we,
    input  logic [1:0]  i_pat_voice,
    input  logic [15:0] i_pat_data,
    input  logic [2:0]  i_manual_trig,
    input  logic [2:0]  i_voice_done,
    output logic        o_sample_en,
    output logic [2:0]  o_voice_go,
    output logic [2:0]  o_voice_busy,
    output logic [3:0]  o_step,
    output logic        o_step_pulse,
    output logic [1:0]  o_rom_sel,
    output logic        o_rom_valid,
    output logic        o_dbg_play
);

    localparam int DIV_W  = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam int TICK_W = (SAMPLES_PER_STEP > 1) ? $clog2(SAMPLES_PER_STEP) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_PER_SAMPLE - 1);
    localparam logic [DIV_W-1:0]  DIV_PRE   = DIV_W'(CLK_PER_SAMPLE - 2);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLES_PER_STEP - 1);
    localparam logic [3:0]        STEP_MASK = 4'(STEPS - 1);
    localparam logic [1:0]        SLOT_LAST = 2'(NUM_VOICES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DIV_W-1:0]    r_div;
    logic                r_sample_en;
    logic [TICK_W-1:0]   r_tick;
    logic [TICK_W-1:0]   w_tick_next;
    logic [3:0]          r_step;
    logic [3:0]          w_step_next;
    logic                r_step_pulse;
    logic                w_fire;
    logic [15:0]         r_pat [NUM_VOICES];
    logic [2:0]          r_go;
    logic [2:0]          w_go_next;
    logic [2:0]          r_busy;
    logic [2:0]          w_busy_next;
    logic                r_slot_on;
    logic                w_slot_on_next;
    logic [1:0]          r_rom_sel;
    logic [1:0]          w_rom_sel_next;
    logic                r_rom_valid;
    logic                w_rom_valid_next;

    // sample_en is registered one count early so it is high while div==CLK_PER_SAMPLE-1.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div       <= '0;
            r_sample_en <= 1'b0;
        end else begin
            r_div       <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            r_sample_en <= (r_div == DIV_PRE);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick;
        w_step_next  = r_step;
        w_fire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_state_next = S_PLAY;
                    w_tick_next  = '0;
                    w_step_next  = '0;
                    w_fire       = 1'b1;
                end
            end
            S_PLAY: begin
                if (!i_run) begin
                    // Stopping wins over a coincident step boundary: nothing fires.
                    w_state_next = S_IDLE;
                    w_tick_next  = '0;
                end else if (r_sample_en) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_next = '0;
                        w_step_next = (r_step + 4'd1) & STEP_MASK;
                        w_fire      = 1'b1;
                    end else begin
                        w_tick_next = r_tick + TICK_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The fire looks up the step being entered; a same-edge pattern write is not yet visible.
    always_comb begin
        w_go_next = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_go_next[v] = (w_fire & r_pat[v][w_step_next]) | i_manual_trig[v];
        end
        w_busy_next = (r_busy & ~i_voice_done) | r_go;
    end

    always_comb begin
        w_slot_on_next   = 1'b0;
        w_rom_sel_next   = '0;
        w_rom_valid_next = 1'b0;
        if (r_sample_en) begin
            w_slot_on_next = 1'b1;
        end else if (r_slot_on && (r_rom_sel != SLOT_LAST)) begin
            w_slot_on_next = 1'b1;
            w_rom_sel_next = r_rom_sel + 2'd1;
        end
        // Uses next-cycle busy so rom_valid matches voice_busy in the slot cycle itself.
        w_rom_valid_next = w_slot_on_next & w_busy_next[w_rom_sel_next];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tick       <= '0;
            r_step       <= '0;
            r_step_pulse <= 1'b0;
            r_go         <= '0;
            r_busy       <= '0;
            r_slot_on    <= 1'b0;
            r_rom_sel    <= '0;
            r_rom_valid  <= 1'b0;
        end else begin
            r_tick       <= w_tick_next;
            r_step       <= w_step_next;
            r_step_pulse <= w_fire;
            r_go         <= w_go_next;
            r_busy       <= w_busy_next;
            r_slot_on    <= w_slot_on_next;
            r_rom_sel    <= w_rom_sel_next;
            r_rom_valid  <= w_rom_valid_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_pat[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (i_pat_we && (i_pat_voice == 2'(v))) begin
                    r_pat[v] <= i_pat_data;
                end
            end
        end
    end

    assign o_sample_en  = r_sample_en;
    assign o_voice_go   = r_go;
    assign o_voice_busy = r_busy;
    assign o_step       = r_step;
    assign o_step_pulse = r_step_pulse;
    assign o_rom_sel    = r_rom_sel;
    assign o_rom_valid  = r_rom_valid;
    assign o_dbg_play   = (r_state == S_PLAY);

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Bench for drum_step_sequencer: directed scenarios plus random traffic, all checked
// cycle by cycle against a tick-count based reference model.
module tb_drum_step_sequencer;

    localparam int CPS    = 8;
    localparam int SPS    = 4;
    localparam int NSTEPS = 16;
    localparam int NV     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        pat_we;
    logic [1:0]  pat_voice;
    logic [15:0] pat_data;
    logic [2:0]  manual_trig;
    logic [2:0]  voice_done;
    logic        o_sample_en;
    logic [2:0]  o_voice_go;
    logic [2:0]  o_voice_busy;
    logic [3:0]  o_step;
    logic        o_step_pulse;
    logic [1:0]  o_rom_sel;
    logic        o_rom_valid;
    logic        o_dbg_play;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: values expected in the current cycle
    int          m_cyc;
    int          m_play_ticks;
    logic        m_playing;
    logic [15:0] m_pat [NV];
    logic        e_sample_en;
    logic [2:0]  e_go;
    logic [2:0]  e_busy;
    logic [3:0]  e_step;
    logic        e_pulse;
    logic [1:0]  e_rom_sel;
    logic        e_rom_valid;

    drum_step_sequencer #(
        .NUM_VOICES       (NV),
        .STEPS            (NSTEPS),
        .CLK_PER_SAMPLE   (CPS),
        .SAMPLES_PER_STEP (SPS)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_run         (run),
        .i_pat_we      (pat_we),
        .i_pat_voice   (pat_voice),
        .i_pat_data    (pat_data),
        .i_manual_trig (manual_trig),
        .i_voice_done  (voice_done),
        .o_sample_en   (o_sample_en),
        .o_voice_go    (o_voice_go),
        .o_voice_busy  (o_voice_busy),
        .o_step        (o_step),
        .o_step_pulse  (o_step_pulse),
        .o_rom_sel     (o_rom_sel),
        .o_rom_valid   (o_rom_valid),
        .o_dbg_play    (o_dbg_play)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc        = 0;
        m_play_ticks = 0;
        m_playing    = 1'b0;
        for (int v = 0; v < NV; v++) m_pat[v] = '0;
        e_sample_en = 1'b0;
        e_go        = '0;
        e_busy      = '0;
        e_step      = '0;
        e_pulse     = 1'b0;
        e_rom_sel   = '0;
        e_rom_valid = 1'b0;
    endtask

    // Step position is derived from sample ticks counted since playback started.
    task automatic model_advance();
        int         n1;
        logic       fire;
        logic [3:0] step_n;
        logic [2:0] go_n;
        logic [2:0] busy_n;
        n1     = m_cyc + 1;
        fire   = 1'b0;
        step_n = e_step;
        if (!m_playing) begin
            if (run) begin
                m_playing    = 1'b1;
                m_play_ticks = 0;
                step_n       = 4'd0;
                fire         = 1'b1;
            end
        end else if (!run) begin
            m_playing    = 1'b0;
            m_play_ticks = 0;
        end else if (e_sample_en) begin
            m_play_ticks++;
            if (m_play_ticks % SPS == 0) begin
                fire   = 1'b1;
                step_n = 4'((m_play_ticks / SPS) % NSTEPS);
            end
        end
        for (int v = 0; v < NV; v++) begin
            go_n[v]   = (fire && m_pat[v][step_n]) || manual_trig[v];
            busy_n[v] = e_go[v] ? 1'b1 : (voice_done[v] ? 1'b0 : e_busy[v]);
        end
        if (pat_we && pat_voice < 2'd3) m_pat[pat_voice] = pat_data;
        e_sample_en = (n1 % CPS == CPS - 1);
        e_go        = go_n;
        e_busy      = busy_n;
        e_step      = step_n;
        e_pulse     = fire;
        if (n1 >= CPS && (n1 % CPS) < NV) begin
            e_rom_sel   = 2'(n1 % CPS);
            e_rom_valid = busy_n[e_rom_sel];
        end else begin
            e_rom_sel   = '0;
            e_rom_valid = 1'b0;
        end
        m_cyc = n1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".sample_en"}, o_sample_en, e_sample_en);
        check({tag, ".go"}, o_voice_go, e_go);
        check({tag, ".busy"}, o_voice_busy, e_busy);
        check({tag, ".step"}, o_step, e_step);
        check({tag, ".pulse"}, o_step_pulse, e_pulse);
        check({tag, ".rom_sel"}, o_rom_sel, e_rom_sel);
        check({tag, ".rom_valid"}, o_rom_valid, e_rom_valid);
        check({tag, ".play"}, o_dbg_play, m_playing);
    endtask

    task automatic cycle(input string tag);
        model_advance();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic run_to_step(input int s, input int budget, input string tag, output int k);
        k = 0;
        do begin
            cycle(tag);
            k++;
        end while (!(o_step_pulse && o_step == 4'(s)) && k < budget);
        check({tag, ".reached"}, {o_step_pulse, o_step}, {1'b1, 4'(s)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int se_cnt;
        int k;
        rst         = 1'b1;
        run         = 1'b0;
        pat_we      = 1'b0;
        pat_voice   = '0;
        pat_data    = '0;
        manual_trig = '0;
        voice_done  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all("in_reset");
        rst = 1'b0;
        model_reset();
        compare_all("post_reset");

        se_cnt = 0;
        repeat (40) begin
            cycle("idle");
            if (o_sample_en) se_cnt++;
        end
        check("idle_sample_en_count", se_cnt, 5);

        manual_trig = 3'b001;
        cycle("manual");
        manual_trig = '0;
        check("manual_go", o_voice_go, 3'b001);
        cycle("manual");
        check("manual_busy", o_voice_busy, 3'b001);
        repeat (5) cycle("manual_hold");
        voice_done = 3'b001;
        cycle("done");
        voice_done = '0;
        check("done_clears_busy", o_voice_busy, 3'b000);

        pat_we = 1'b1; pat_voice = 2'd2; pat_data = 16'h0011;
        cycle("pat_write");
        pat_voice = 2'd3; pat_data = 16'hFFFF;
        cycle("pat_noop");
        pat_we = 1'b0;

        run = 1'b1;
        cycle("start");
        check("start_fire", {o_step_pulse, o_voice_go, o_step}, {1'b1, 3'b100, 4'd0});
        repeat (10) cycle("play");
        manual_trig = 3'b001;
        cycle("play_manual");
        manual_trig = '0;
        cycle("play_manual");
        check("busy_101", o_voice_busy, 3'b101);

        k = 0;
        while (!o_sample_en && k < 2 * CPS) begin
            cycle("wait_se");
            k++;
        end
        check("sample_en_seen", o_sample_en, 1'b1);
        for (int s = 0; s < NV; s++) begin
            cycle("rom_slot");
            check("rom_slot", {o_rom_sel, o_rom_valid}, {2'(s), (s != 1) ? 1'b1 : 1'b0});
        end
        cycle("rom_after");
        check("rom_after_window", o_rom_valid, 1'b0);

        run_to_step(4, 200, "to_step4", k);
        check("step4_fire", o_voice_go, 3'b100);
        voice_done = 3'b100;
        cycle("go_wins");
        check("go_wins_busy2", o_voice_busy[2], 1'b1);
        cycle("done2");
        voice_done = '0;
        check("done2_clears", o_voice_busy[2], 1'b0);

        run_to_step(15, 600, "to_step15", k);
        run_to_step(0, 100, "wrap", k);
        check("wrap_gap", k, SPS * CPS);
        check("wrap_fire", o_voice_go, 3'b100);

        run_to_step(5, 300, "to_step5", k);
        run = 1'b0;
        repeat (30) cycle("stopped");
        check("stopped_step", o_step, 4'd5);
        run = 1'b1;
        cycle("restart");
        check("restart_fire", {o_step_pulse, o_voice_go, o_step}, {1'b1, 3'b100, 4'd0});
        repeat (50) cycle("replay");

        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        compare_all("after_reset");
        cycle("reset_restart");
        check("reset_restart_fire", {o_step_pulse, o_voice_go, o_step}, {1'b1, 3'b000, 4'd0});

        repeat (3000) begin
            if ($urandom_range(0, 99) < 3) run = ~run;
            pat_we    = ($urandom_range(0, 19) == 0);
            pat_voice = 2'($urandom_range(0, 3));
            pat_data  = 16'($urandom);
            for (int v = 0; v < NV; v++) begin
                manual_trig[v] = ($urandom_range(0, 99) < 3);
                voice_done[v]  = ($urandom_range(0, 99) < 10);
            end
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drum_step_sequencer.md
Name: drum_step_sequencer

Overview:
- Central sequencer for the drum-machine playback path.
- Generates the shared sample-rate enable and runs a 16-step pattern per voice at a fixed tempo.
- Issues one-cycle go pulses to each voice's sample-address counter and tracks which voices are playing.
- Time-slots the single shared sample ROM between busy voices after every sample tick, so the mixer sees one address owner per cycle.

Parameters:
- NUM_VOICES, 3: voices driven (kick, snare, cymbal). Fixed at 3 by the port widths.
- STEPS, 16: steps per pattern. Must be a power of two, at most 16.
- CLK_PER_SAMPLE, 1042: clocks per audio sample tick. Must be greater than NUM_VOICES+1.
- SAMPLES_PER_STEP, 6000: sample ticks per step; this sets the tempo.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  level; pattern playback advances while high
- pat_we  in  1  pattern write strobe
- pat_voice  in  2  voice index for the write; values 3 and above are ignored
- pat_data  in  16  step mask; bit i means "fire at step i"
- manual_trig  in  3  per-voice immediate trigger, sampled every cycle
- voice_done  in  3  per-voice level from the counter: 1 when it has reached MAXCOUNT
- sample_en  out  1  one-cycle tick every CLK_PER_SAMPLE clocks; drives the counters' en
- voice_go  out  3  one-cycle restart pulse per voice; drives the counters' go
- voice_busy  out  3  voice is currently playing
- step  out  4  current step index
- step_pulse  out  1  one-cycle pulse when a step fires
- rom_sel  out  2  voice owning the shared ROM this cycle
- rom_valid  out  1  rom_sel is a busy voice and the ROM read is needed

Behaviour:
- Reset (asynchronous): all outputs 0, all patterns 0, step 0, all internal counters 0.
- All outputs are registered.
- Sample divider:
  - div counts 0..CLK_PER_SAMPLE-1, free-running and independent of run.
  - sample_en=1 for exactly the one cycle in which div==CLK_PER_SAMPLE-1.
- Sequencer state machine, states IDLE and PLAY:
  - IDLE, run=1: go to PLAY; step<=0, tick counter<=0; step_pulse=1 on the next cycle, so step 0 fires immediately.
  - PLAY: each sample_en increments the tick counter. When tick==SAMPLES_PER_STEP-1 and sample_en=1: tick<=0, step<=(step+1) mod STEPS, step_pulse=1 the same cycle step updates. Step wrap from STEPS-1 to 0 is seamless.
  - PLAY, run=0: go to IDLE the next cycle. step holds its value, the tick counter clears, and no further pattern fires.
- Triggering:
  - On a step_pulse cycle, voice_go[v]=pattern[v][step] for the step just entered, in the same cycle as step_pulse.
  - manual_trig[v]=1 in cycle n gives voice_go[v]=1 in cycle n+1. Manual and pattern triggers are ORed and produce a single pulse.
  - Manual triggers work in both IDLE and PLAY.
- Busy tracking:
  - voice_busy[v] is set in the cycle after voice_go[v].
  - It clears in the cycle after voice_done[v]=1 is sampled, unless go is pending in the same cycle; go wins.
  - Retrigger of a busy voice is legal: a go pulse is issued and busy stays 1.
- Pattern write:
  - pat_we=1 with pat_voice<3 loads pattern[pat_voice]<=pat_data at the clock edge; the new pattern takes effect the next cycle.
  - A write coinciding with a step fire uses the old pattern for that fire.
  - pat_voice=3 is a no-op.
- ROM scheduler:
  - slot counter k runs from 0 to NUM_VOICES-1 over the NUM_VOICES cycles immediately after each sample_en cycle.
  - In those cycles rom_sel=k and rom_valid=voice_busy[k].
  - Outside the slot window, rom_sel=0 and rom_valid=0.
  - The order is fixed with no skipping, so latency from sample_en to a voice's slot is exactly k+1 cycles.
- Simultaneous events:
  - A reset assertion at any time aborts playback immediately.
  - After reset deasserts, the block is in IDLE; if run is still 1, playback restarts at step 0 with patterns cleared.

Test Plan (bench uses CLK_PER_SAMPLE=8, SAMPLES_PER_STEP=4, STEPS=16):
- Reset, then idle 40 cycles -> sample_en pulses at cycles 7, 15, 23, 31, 39 after reset release; voice_go=0; step=0.
- Write pattern[2]=16'h0011, then raise run -> step_pulse and voice_go=3'b100 one cycle later at step 0; next step_pulse after 4 sample_en; voice 2 fires again at step 4; step wraps from 15 to 0 after 64 ticks.
- manual_trig=3'b001 for one cycle while IDLE -> voice_go=3'b001 the next cycle, voice_busy[0]=1 after that; voice_done[0]=1 -> busy[0]=0 the next cycle.
- voice_done[2]=1 in the same cycle as a pattern fire for voice 2 -> voice_go[2]=1 and voice_busy[2] stays 1.
- voice_busy=3'b101 -> in the 3 cycles after sample_en, rom_sel=0,1,2 with rom_valid=1,0,1; all other cycles rom_valid=0.
- Drop run at step 5 -> step holds 5 and no fires; raise run again -> restart at step 0 with an immediate fire. Assert reset mid-playback -> all outputs 0 asynchronously and patterns cleared.
